seq_pattern_tx: RTL and testbench

- Serial pattern transmitter. Serializes a programmable PAT_W-bit pattern MSB-first onto a single-bit stream, repeated a programmable number of times.
- Drives the din input of the team's sequence-detector blocks, in both bring-up and self-test.
- Start/busy/done handshake toward the control side; per-bit valid qualifier toward the serial side.

---
 rtl/seq_pattern_tx.sv | 162 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first, repeated N times.
// Optional SEQ_TX_GAP_EN inserts one invalid cycle between repetitions.
module seq_pattern_tx #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_cnt,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
`ifdef SEQ_TX_GAP_EN
      GAP   = 2'd2,
`endif
      FIN   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PAT_W-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] rep_q, rep_d;
   logic             dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d   = state_q;
      pat_d     = pat_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      rep_d     = rep_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               pat_d     = pattern;
               rep_d     = repeat_cnt;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               if (repeat_cnt != '0) begin
                  state_d = SHIFT;
                  dout_d  = pattern[PAT_W-1];
                  valid_d = 1'b1;
                  shreg_d = {pattern[PAT_W-2:0], 1'b0};
               end else begin
                  state_d = FIN;
               end
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
               dout_d  = 1'b0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else if (bit_cnt_q == LAST_BIT) begin
               rep_d = rep_q - CNT_W'(1);
               if (rep_q == CNT_W'(1)) begin
                  state_d = FIN;
                  dout_d  = 1'b0;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
`ifdef SEQ_TX_GAP_EN
                  state_d = GAP;
                  dout_d  = 1'b0;
                  valid_d = 1'b0;
`else
                  // Reload from the latched copy so live input changes never leak in
                  dout_d    = pat_q[PAT_W-1];
                  shreg_d   = {pat_q[PAT_W-2:0], 1'b0};
                  bit_cnt_d = '0;
`endif
               end
            end else begin
               dout_d    = shreg_q[PAT_W-1];
               shreg_d   = {shreg_q[PAT_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end
`ifdef SEQ_TX_GAP_EN
         GAP: begin
            if (abort) begin
               state_d = IDLE;
               dout_d  = 1'b0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end else begin
               state_d   = SHIFT;
               dout_d    = pat_q[PAT_W-1];
               valid_d   = 1'b1;
               shreg_d   = {pat_q[PAT_W-2:0], 1'b0};
               bit_cnt_d = '0;
            end
         end
`endif
         FIN: begin
            // A zero-repeat job enters FIN without done, so it lingers one cycle to pulse it
            if (done_q) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               done_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            dout_d  = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         rep_q     <= '0;
         dout_q    <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         rep_q     <= rep_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: per-cycle {busy,valid,dout,done} expectations
// for a 4-bit and an 8-bit instance, plus a 1001 overlap detector on the 4-bit stream.
module tb_seq_pattern_tx;

`ifdef SEQ_TX_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       a_start, a_abort, a_dout, a_valid, a_busy, a_done;
   logic [3:0] a_pat, a_cnt;
   logic       b_start, b_abort, b_dout, b_valid, b_busy, b_done;
   logic [7:0] b_pat;
   logic [3:0] b_cnt;

   int         n_chk = 0;
   int         n_bad = 0;
   bit         mon_on = 1'b0;
   logic [3:0] q_a[$];
   logic [3:0] q_b[$];
   logic [3:0] hist;
   int         det;

   always #5 clk = ~clk;

   seq_pattern_tx #(.PAT_W(4), .CNT_W(4)) u_a (
      .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
      .pattern(a_pat), .repeat_cnt(a_cnt),
      .dout(a_dout), .dout_valid(a_valid), .busy(a_busy), .done(a_done)
   );

   seq_pattern_tx #(.PAT_W(8), .CNT_W(4)) u_b (
      .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
      .pattern(b_pat), .repeat_cnt(b_cnt),
      .dout(b_dout), .dout_valid(b_valid), .busy(b_busy), .done(b_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input bit sel_b, input logic [3:0] v);
      if (sel_b) q_b.push_back(v);
      else       q_a.push_back(v);
   endtask

   // Model of one job as seen in the cycles after the start edge
   task automatic push_job(input bit sel_b, input logic [15:0] pat, input int w, input int n);
      if (n == 0) begin
         push(sel_b, 4'b1000);
         push(sel_b, 4'b1001);
      end else begin
         for (int r = 0; r < n; r++) begin
            for (int b = 0; b < w; b++) push(sel_b, {2'b11, pat[w-1-b], 1'b0});
            if (GAP && r < n - 1) push(sel_b, 4'b1000);
         end
         push(sel_b, 4'b1001);
      end
      push(sel_b, 4'b0000);
   endtask

   task automatic start_job(input bit sel_b, input logic [7:0] pat, input logic [3:0] n,
                            input bit with_abort);
      @(negedge clk);
      if (sel_b) begin b_pat = pat; b_cnt = n; b_start = 1'b1; b_abort = with_abort; end
      else       begin a_pat = pat[3:0]; a_cnt = n; a_start = 1'b1; a_abort = with_abort; end
      @(posedge clk);
      push_job(sel_b, {8'h00, pat}, sel_b ? 8 : 4, int'(n));
      @(negedge clk);
      a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
   endtask

   task automatic wait_drain(input bit sel_b);
      for (int i = 0; i < 400 && (sel_b ? q_b.size() : q_a.size()) != 0; i++) @(posedge clk);
      chk(sel_b ? "b_timeout" : "a_timeout", sel_b ? q_b.size() : q_a.size(), 0);
      q_a.delete();
      q_b.delete();
      repeat (2) @(posedge clk);
   endtask

   // Mid-job interruption of a 1011 x2 job after its second bit, by abort or reset
   task automatic interrupt_job(input bit by_reset);
      @(negedge clk);
      a_pat = 4'b1011; a_cnt = 4'd2; a_start = 1'b1;
      @(posedge clk);
      push(1'b0, 4'b1110);
      push(1'b0, 4'b1100);
      push(1'b0, 4'b0000);
      @(negedge clk);
      a_start = 1'b0;
      @(negedge clk);
      if (by_reset) reset = 1'b1;
      else          a_abort = 1'b1;
      @(negedge clk);
      reset = 1'b0; a_abort = 1'b0;
      wait_drain(1'b0);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (q_a.size() != 0) chk("a_out", {a_busy, a_valid, a_dout, a_done}, q_a.pop_front());
         else                 chk("a_idle", {a_busy, a_valid, a_dout, a_done}, 0);
         if (q_b.size() != 0) chk("b_out", {b_busy, b_valid, b_dout, b_done}, q_b.pop_front());
         else                 chk("b_idle", {b_busy, b_valid, b_dout, b_done}, 0);
         if (a_valid) begin
            if ({hist[2:0], a_dout} == 4'b1001) det++;
            hist = {hist[2:0], a_dout};
         end
      end
   end

   initial begin
      reset = 1'b1;
      a_start = 1'b0; a_abort = 1'b0; a_pat = '0; a_cnt = '0;
      b_start = 1'b0; b_abort = 1'b0; b_pat = '0; b_cnt = '0;
      hist = '0; det = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_state", {a_busy, a_valid, a_dout, a_done, b_busy, b_valid, b_dout, b_done}, 0);
      reset = 1'b0;
      mon_on = 1'b1;

      start_job(1'b0, 8'h09, 4'd1, 1'b0);
      wait_drain(1'b0);

      hist = '0; det = 0;
      start_job(1'b0, 8'h09, 4'd3, 1'b0);
      wait_drain(1'b0);
      chk("detect", det, 3);

      start_job(1'b0, 8'h09, 4'd0, 1'b0);
      wait_drain(1'b0);

      // Start and new inputs during a job must be ignored
      @(negedge clk);
      a_pat = 4'b1001; a_cnt = 4'd2; a_start = 1'b1;
      @(posedge clk);
      push_job(1'b0, 16'h0009, 4, 2);
      @(negedge clk);
      a_start = 1'b0;
      repeat (2) @(negedge clk);
      a_pat = 4'b0110; a_cnt = 4'd5; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      wait_drain(1'b0);

      interrupt_job(1'b0);
      interrupt_job(1'b1);
      start_job(1'b0, 8'h0B, 4'd1, 1'b0);
      wait_drain(1'b0);

      // Abort is a no-op in IDLE, so start wins
      start_job(1'b0, 8'h06, 4'd2, 1'b1);
      wait_drain(1'b0);

      start_job(1'b1, 8'hA5, 4'd15, 1'b0);
      wait_drain(1'b1);
      start_job(1'b1, 8'h3C, 4'd2, 1'b0);
      wait_drain(1'b1);

      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
